// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes driven by the ALU control decoder
// and the state encoding of the execute-stage sequencer.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_mul(input logic [2:0] ctrl);
    return ctrl == ALU_MUL;
  endfunction

endpackage

// File: rtl/iterative_alu_if.sv
// Execute-stage ALU bus: operands and control from ID/EX, result and stall back.
// Signal directions in the names are from the ALU's point of view.
interface iterative_alu_if #(
  parameter int WIDTH = 32
);

  logic             valid_i;
  logic             flush_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             stall_o;

  modport master (
    output valid_i, flush_i, ALUCtrl_i, data1_i, data2_i,
    input  data_o, zero_o, stall_o
  );

  modport slave (
    input  valid_i, flush_i, ALUCtrl_i, data1_i, data2_i,
    output data_o, zero_o, stall_o
  );

endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles
// per multiply; only the low WIDTH bits of the product are kept.
module shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;

    if (abort_i) begin
      busy_d = 1'b0;
    end else if (start_i && !busy_q) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      prod_d   = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST_ITER) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge, independent of block order.
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o    = busy_q;
  // High during the final iteration: the product register is complete after this edge.
  assign done_o    = busy_q && (cnt_q == LAST_ITER);
  assign product_o = prod_q;

endmodule

// File: rtl/iterative_alu.sv
// Execute-stage ALU: single-cycle add/sub/and/or, multi-cycle multiply that
// stalls the front of the pipeline until the product is ready.
module iterative_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  iterative_alu_if.slave bus
);

  alu_state_e       state_q, state_d;
  logic             mul_start, mul_abort, mul_busy, mul_done;
  logic             stall;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] comb_result;
  logic [WIDTH-1:0] result;

  shift_add_multiplier #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .abort_i   (mul_abort),
    .a_i       (bus.data1_i),
    .b_i       (bus.data2_i),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (product)
  );

  // Unused codes 101..111 fall through to add.
  always_comb begin
    comb_result = bus.data1_i + bus.data2_i;
    case (bus.ALUCtrl_i)
      ALU_SUB: comb_result = bus.data1_i - bus.data2_i;
      ALU_AND: comb_result = bus.data1_i & bus.data2_i;
      ALU_OR:  comb_result = bus.data1_i | bus.data2_i;
      ALU_MUL: comb_result = '0;
      default: comb_result = bus.data1_i + bus.data2_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    mul_abort = 1'b0;
    stall     = 1'b0;
    result    = comb_result;

    case (state_q)
      ST_IDLE: begin
        if (is_mul(bus.ALUCtrl_i) && bus.valid_i && !bus.flush_i) begin
          mul_start = 1'b1;
          stall     = 1'b1;
          state_d   = ST_MUL;
        end
      end
      ST_MUL: begin
        result = '0;
        if (bus.flush_i) begin
          mul_abort = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          stall = 1'b1;
          if (mul_done) begin
            state_d = ST_DONE;
          end else if (!mul_busy) begin
            // Multiplier lost its operation; never hold the pipeline forever.
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        result  = product;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.data_o  = result;
  assign bus.zero_o  = (result == '0);
  assign bus.stall_o = stall && !rst_i;

endmodule

// File: doc/iterative_alu.md
# iterative_alu

Execute-stage ALU consuming the 3-bit ALU control code produced by the ALU control decoder. Add, sub, and, or complete in the same cycle. Mul runs on an iterative shift-add multiplier and stalls the pipeline until its result is ready. Sits in EX between the ID/EX and EX/MEM pipeline registers; its `stall_o` feeds the hazard/stall logic.

## Interface
- `WIDTH`, 32, operand and result width; mul iteration count equals `WIDTH`.
- `clk_i` input 1 — clock, rising edge.
- `rst_i` input 1 — asynchronous, active-high reset.
- `valid_i` input 1 — EX stage holds a live instruction.
- `flush_i` input 1 — kill current EX instruction (branch/exception).
- `ALUCtrl_i` input 3 — 000 add, 001 sub, 010 mul, 011 and, 100 or; 101–111 behave as add.
- `data1_i` input WIDTH — operand A.
- `data2_i` input WIDTH — operand B.
- `data_o` output WIDTH — result.
- `zero_o` output 1 — `data_o == 0`.
- `stall_o` output 1 — freeze PC, IF/ID, ID/EX; bubble into EX/MEM.

## Operation
- States: IDLE, MUL, DONE. Reset → IDLE, product/multiplicand/multiplier registers and counter cleared.
- `rst_i` high forces `stall_o = 0`; `data_o` and `zero_o` follow IDLE rules.
- IDLE, non-mul op: `data_o` is combinational from inputs; `stall_o = 0`.
  - add/sub wrap mod 2^WIDTH (two's complement).
  - and/or are bitwise.
- IDLE, `valid_i=1`, mul, `flush_i=0`:
  - Capture operands, clear product, counter ← 0, go to MUL.
  - `stall_o = 1` combinationally this cycle; `data_o = 0`.
- MUL, each cycle:
  - If multiplier LSB is 1, product += multiplicand.
  - Multiplicand <<= 1, multiplier >>= 1, counter += 1.
  - `stall_o = 1`, `data_o = 0`.
  - After iteration `WIDTH` (counter reaches WIDTH−1 and completes), go to DONE.
- DONE: `data_o` = product register (low WIDTH bits, identical for signed and unsigned); `stall_o = 0`; unconditionally return to IDLE next cycle.
- `flush_i` in MUL or DONE: go to IDLE next edge and drop `stall_o` the same cycle. `flush_i` in IDLE blocks mul start.
- Captured operands are used during MUL; input changes during MUL are ignored.
- `valid_i=0` in IDLE: `data_o` still computed; `stall_o = 0`.

## Timing
- Non-mul ops: 0-cycle latency, combinational.
- Mul accepted in cycle T: `stall_o` is high T..T+WIDTH (WIDTH+1 cycles). Result is valid in cycle T+WIDTH+1 (DONE, `stall_o` low), and the pipeline advances at the end of that cycle.
- Back-to-back mul: the second instruction arrives in cycle T+WIDTH+2 (IDLE) and starts normally; there is no spurious restart from DONE.
- Reset during MUL: immediate return to IDLE; the multiply is lost.

## Structure
- Shared package `alu_pkg`:
  - Op-code constants `ALU_ADD`, `ALU_SUB`, `ALU_MUL`, `ALU_AND`, `ALU_OR`, also used by the ALU control decoder.
  - State encoding for IDLE/MUL/DONE.
- One sub-module, `shift_add_multiplier`:
  - Ports: `clk_i`, `rst_i`, `start_i`, `abort_i`, `a_i`, `b_i`, `busy_o`, `done_o`, `product_o`.
  - Owns the iteration registers and counter.
- The top level holds the combinational ops, result mux, and stall logic.

## Test plan
- add 0x7FFFFFFF + 1 → `data_o` 0x80000000, `zero_o` 0, `stall_o` 0 in the same cycle. sub 5−5 → 0, `zero_o` 1.
- and 0xF0F0F0F0 & 0xFF00FF00 → 0xF000F000. or → 0xFFF0FFF0. Ctrl 111 with 3,4 → 7.
- mul 7×6 at cycle T: `stall_o` high for exactly 33 cycles (T..T+32); cycle T+33 gives `data_o` 42 with `stall_o` 0. Changing operands mid-mul has no effect.
- mul 0xFFFFFFFD×5 → 0xFFFFFFF1. mul 0x10000×0x10000 → 0, `zero_o` 1.
- Two consecutive muls 2×3 then 4×5: results 6 then 20. Total stall = 66 cycles, one DONE cycle each.
- `flush_i` at iteration 10: `stall_o` low the same cycle, IDLE next cycle, no result. Async `rst_i` pulse mid-mul: `stall_o` drops immediately, following add works normally.
